// File: rtl/johnson_decoder.sv
// Johnson-code receive checker: decodes a WIDTH-bit twisted-ring word to its index, flags illegal words, tracks sequence lock.
// Latency: all outputs are registered and appear 1 cycle after the sampling edge; pulses are 1 cycle wide.
// Backpressure: none; a word is sampled whenever code_vld=1. Optional JDEC_ERR_CNT_EN enables the saturating error counter.
module johnson_decoder #(
    parameter  int WIDTH    = 4,
    parameter  int LOCK_CNT = 2,
    localparam int IW       = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] code_in,
    input  logic             code_vld,
    output logic [IW-1:0]    idx_out,
    output logic             idx_vld,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [IW:0]   SEQ_LEN  = (IW + 1)'(2 * WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * WIDTH - 1);
    localparam logic [3:0]    LOCK_TGT = 4'(LOCK_CNT);

    state_t          state;
    logic [3:0]      run_cnt;
    logic [IW-1:0]   prev_idx;

    logic            is_legal;
    logic [IW-1:0]   ones;
    logic [IW-1:0]   idx_dec;
    logic [IW-1:0]   next_idx;
    logic            is_succ;
    logic [3:0]      run_inc;

    // A Johnson word has at most one change between adjacent bits; count those changes and the ones
    always_comb begin
        int trans;
        trans = 0;
        ones  = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (code_in[i] != code_in[i+1]) begin
                trans = trans + 1;
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + IW'(code_in[i]);
        end
        is_legal = (trans <= 1);
    end

    // Filling phase (LSB set, or all zero) maps to popcount; draining phase maps to 2*WIDTH - popcount
    always_comb begin
        idx_dec = '0;
        if (code_in[0] || (code_in == '0)) begin
            idx_dec = ones;
        end else begin
            idx_dec = IW'(SEQ_LEN - {1'b0, ones});
        end
    end

    // Expected successor of the previous legal sample, wrapping at the end of the ring
    always_comb begin
        next_idx = (prev_idx == LAST_IDX) ? '0 : prev_idx + 1'b1;
        is_succ  = (idx_dec == next_idx);
        run_inc  = run_cnt + 4'd1;
    end

    // Lock-tracking FSM with registered index and event pulses
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= UNLOCK;
            run_cnt  <= 4'd0;
            prev_idx <= '0;
            idx_out  <= '0;
            idx_vld  <= 1'b0;
            illegal  <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            idx_vld <= 1'b0;
            illegal <= 1'b0;
            seq_err <= 1'b0;
            if (code_vld) begin
                if (is_legal) begin
                    idx_vld  <= 1'b1;
                    idx_out  <= idx_dec;
                    prev_idx <= idx_dec;
                end else begin
                    illegal <= 1'b1;
                end
                case (state)
                    UNLOCK: begin
                        if (is_legal) begin
                            state   <= TRACK;
                            run_cnt <= 4'd0;
                        end
                    end
                    TRACK: begin
                        if (!is_legal) begin
                            state   <= UNLOCK;
                            run_cnt <= 4'd0;
                        end else if (is_succ) begin
                            run_cnt <= run_inc;
                            if (run_inc == LOCK_TGT) begin
                                state <= LOCKED;
                            end
                        end else begin
                            run_cnt <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (!is_legal) begin
                            state   <= UNLOCK;
                            run_cnt <= 4'd0;
                        end else if (!is_succ) begin
                            seq_err <= 1'b1;
                            state   <= TRACK;
                            run_cnt <= 4'd0;
                        end
                    end
                    default: begin
                        state   <= UNLOCK;
                        run_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

    // locked is a direct decode of the registered state, so it is glitch-free and one cycle after the event
    assign locked = (state == LOCKED);

`ifdef JDEC_ERR_CNT_EN
    logic err_evt;

    // Illegal and sequence errors are mutually exclusive, so at most one increment per sample
    always_comb begin
        err_evt = code_vld && (!is_legal || ((state == LOCKED) && !is_succ));
    end

    // Saturating error counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt <= 8'd0;
        end else if (err_evt && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder: directed scenarios plus randomized traffic against a table-driven reference model.
// Latency: expectations are updated at each sampling edge and compared 1 time unit later.
// Backpressure: not applicable; the bench drives code_vld freely, including gap cycles.
module tb_johnson_decoder;

    localparam int W  = 4;
    localparam int LC = 2;
    localparam int IW = $clog2(2 * W);

    logic          clk;
    logic          rstn;
    logic [W-1:0]  code_in;
    logic          code_vld;
    logic [IW-1:0] idx_out;
    logic          idx_vld;
    logic          illegal;
    logic          seq_err;
    logic          locked;
    logic [7:0]    err_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model state and expected outputs
    logic [IW-1:0] e_idx;
    logic          e_ivld, e_ill, e_serr, e_lock;
    logic [7:0]    e_cnt;
    int            m_state;   // 0 unlocked, 1 tracking, 2 locked
    int            m_run;
    int            m_prev;

    johnson_decoder #(.WIDTH(W), .LOCK_CNT(LC)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .code_in  (code_in),
        .code_vld (code_vld),
        .idx_out  (idx_out),
        .idx_vld  (idx_vld),
        .illegal  (illegal),
        .seq_err  (seq_err),
        .locked   (locked),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // the i-th word of the Johnson ring, built from the fill/drain description
    function automatic logic [W-1:0] jword(input int i);
        int full;
        full = (1 << W) - 1;
        if (i <= W) return W'((1 << i) - 1);
        return W'(full & ~((1 << (i - W)) - 1));
    endfunction

    // index of a word in the ring, or -1 if it is not a ring member
    function automatic int jlookup(input logic [W-1:0] c);
        for (int i = 0; i < 2 * W; i++) begin
            if (jword(i) == c) return i;
        end
        return -1;
    endfunction

    task automatic bump_err();
`ifdef JDEC_ERR_CNT_EN
        if (e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
`endif
    endtask

    // drive one cycle, advance the model at the sampling edge, settle for comparison
    task automatic drive(input logic v, input logic [W-1:0] c);
        int k;
        bit sc;
        code_vld = v;
        code_in  = c;
        @(posedge clk);
        if (!rstn) begin
            e_idx = '0; e_ivld = 0; e_ill = 0; e_serr = 0; e_cnt = 8'd0;
            m_state = 0; m_run = 0; m_prev = 0;
        end else begin
            e_ivld = 0; e_ill = 0; e_serr = 0;
            if (v) begin
                k = jlookup(c);
                if (k < 0) begin
                    e_ill = 1;
                    bump_err();
                    m_state = 0;
                    m_run = 0;
                end else begin
                    sc = (k == ((m_prev + 1) % (2 * W)));
                    e_ivld = 1;
                    e_idx  = IW'(k);
                    case (m_state)
                        0: begin m_state = 1; m_run = 0; end
                        1: begin
                            if (sc) begin
                                m_run = m_run + 1;
                                if (m_run == LC) m_state = 2;
                            end else begin
                                m_run = 0;
                            end
                        end
                        default: begin
                            if (!sc) begin
                                e_serr = 1;
                                bump_err();
                                m_state = 1;
                                m_run = 0;
                            end
                        end
                    endcase
                    m_prev = k;
                end
            end
        end
        e_lock = (m_state == 2);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'b0011);
            checks++;
            if ({idx_out, idx_vld, illegal, seq_err, locked, err_cnt} !== '0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h want=0", i,
                         {idx_out, idx_vld, illegal, seq_err, locked, err_cnt});
            end
        end
        rstn = 1'b1;
        drive(1'b0, 4'b0011);
        checks++;
        if ({idx_out, idx_vld, illegal, seq_err, locked, err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_release got=%h want=0",
                     {idx_out, idx_vld, illegal, seq_err, locked, err_cnt});
        end
    endtask

    task automatic test_sequence();
        logic [W-1:0] w;
        for (int i = 0; i < 9; i++) begin
            w = jword(i % (2 * W));
            drive(1'b1, w);
            checks++;
            if (idx_out !== IW'(i % 8) || idx_vld !== 1'b1 || locked !== (i >= 2)) begin
                failures++;
                $display("FAIL seq_walk step=%0d got idx=%0d vld=%b lock=%b want idx=%0d vld=1 lock=%b",
                         i, idx_out, idx_vld, locked, i % 8, (i >= 2));
            end
            checks++;
            if ({idx_out, idx_vld, illegal, seq_err, locked, err_cnt} !==
                {e_idx, e_ivld, e_ill, e_serr, e_lock, e_cnt}) begin
                failures++;
                $display("FAIL seq_model step=%0d got=%h want=%h", i,
                         {idx_out, idx_vld, illegal, seq_err, locked, err_cnt},
                         {e_idx, e_ivld, e_ill, e_serr, e_lock, e_cnt});
            end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] cnt_before;
        drive(1'b1, 4'b0001);
        cnt_before = err_cnt;
        drive(1'b1, 4'b0101);
        checks++;
        if (illegal !== 1'b1 || locked !== 1'b0 || idx_out !== 3'd1 || idx_vld !== 1'b0 || seq_err !== 1'b0) begin
            failures++;
            $display("FAIL illegal_word got ill=%b lock=%b idx=%0d vld=%b serr=%b want ill=1 lock=0 idx=1 vld=0 serr=0",
                     illegal, locked, idx_out, idx_vld, seq_err);
        end
        checks++;
`ifdef JDEC_ERR_CNT_EN
        if (err_cnt !== cnt_before + 8'd1) begin
`else
        if (err_cnt !== 8'd0 || cnt_before !== 8'd0) begin
`endif
            failures++;
            $display("FAIL illegal_errcnt got=%0d before=%0d", err_cnt, cnt_before);
        end
        drive(1'b0, 4'b0101);
        checks++;
        if (illegal !== 1'b0 || idx_out !== 3'd1) begin
            failures++;
            $display("FAIL illegal_pulse_width got ill=%b idx=%0d want ill=0 idx=1", illegal, idx_out);
        end
    endtask

    task automatic test_seq_err();
        drive(1'b1, 4'b0001);
        drive(1'b1, 4'b0011);
        drive(1'b1, 4'b0111);
        checks++;
        if (locked !== 1'b1 || idx_out !== 3'd3) begin
            failures++;
            $display("FAIL relock got lock=%b idx=%0d want lock=1 idx=3", locked, idx_out);
        end
        drive(1'b1, 4'b1100);
        checks++;
        if (seq_err !== 1'b1 || illegal !== 1'b0 || idx_out !== 3'd6 || locked !== 1'b0) begin
            failures++;
            $display("FAIL seq_err_jump got serr=%b ill=%b idx=%0d lock=%b want serr=1 ill=0 idx=6 lock=0",
                     seq_err, illegal, idx_out, locked);
        end
        drive(1'b1, 4'b1000);
        drive(1'b1, 4'b0000);
        checks++;
        if (locked !== 1'b1 || seq_err !== 1'b0 || idx_out !== 3'd0) begin
            failures++;
            $display("FAIL seq_err_recover got lock=%b serr=%b idx=%0d want lock=1 serr=0 idx=0",
                     locked, seq_err, idx_out);
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] seq [3];
        seq[0] = 4'b0001; seq[1] = 4'b0011; seq[2] = 4'b0111;
        drive(1'b1, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, seq[i]);
            drive(1'b0, 4'b1010);
            checks++;
            if (idx_vld !== 1'b0 || illegal !== 1'b0 || seq_err !== 1'b0 || idx_out !== IW'(i + 1)) begin
                failures++;
                $display("FAIL gap_quiet step=%0d got vld=%b ill=%b serr=%b idx=%0d want 0 0 0 idx=%0d",
                         i, idx_vld, illegal, seq_err, idx_out, i + 1);
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL gap_lock got=%b want=1", locked);
        end
        drive(1'b1, 4'b0111);
        checks++;
        if (seq_err !== 1'b1 || locked !== 1'b0 || idx_out !== 3'd3 || idx_vld !== 1'b1) begin
            failures++;
            $display("FAIL gap_repeat got serr=%b lock=%b idx=%0d vld=%b want serr=1 lock=0 idx=3 vld=1",
                     seq_err, locked, idx_out, idx_vld);
        end
    endtask

    task automatic test_random();
        int cur;
        int r;
        logic [W-1:0] w;
        cur = 3;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 49);
            rstn = (r != 0);
            if (r < 30) begin
                cur = (cur + 1) % (2 * W);
                drive(1'b1, jword(cur));
            end else if (r < 36) begin
                cur = $urandom_range(0, 2 * W - 1);
                drive(1'b1, jword(cur));
            end else if (r < 42) begin
                w = W'($urandom_range(0, (1 << W) - 1));
                drive(1'b1, w);
            end else begin
                w = W'($urandom_range(0, (1 << W) - 1));
                drive(1'b0, w);
            end
            checks++;
            if ({idx_out, idx_vld, illegal, seq_err, locked, err_cnt} !==
                {e_idx, e_ivld, e_ill, e_serr, e_lock, e_cnt}) begin
                failures++;
                $display("FAIL random n=%0d got=%h want=%h", n,
                         {idx_out, idx_vld, illegal, seq_err, locked, err_cnt},
                         {e_idx, e_ivld, e_ill, e_serr, e_lock, e_cnt});
            end
            checks++;
            if (illegal === 1'b1 && seq_err === 1'b1) begin
                failures++;
                $display("FAIL random_exclusive n=%0d got ill=1 serr=1", n);
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 300; n++) begin
            drive(1'b1, 4'b0101);
            checks++;
            if ({idx_out, idx_vld, illegal, seq_err, locked, err_cnt} !==
                {e_idx, e_ivld, e_ill, e_serr, e_lock, e_cnt}) begin
                failures++;
                $display("FAIL sat_model n=%0d got=%h want=%h", n,
                         {idx_out, idx_vld, illegal, seq_err, locked, err_cnt},
                         {e_idx, e_ivld, e_ill, e_serr, e_lock, e_cnt});
            end
        end
        checks++;
`ifdef JDEC_ERR_CNT_EN
        if (err_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_value got=%0d want=255", err_cnt);
        end
`else
        if (err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL sat_value got=%0d want=0", err_cnt);
        end
`endif
        drive(1'b1, 4'b0000);
        drive(1'b1, 4'b0001);
        drive(1'b1, 4'b0011);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL sat_relock got=%b want=1", locked);
        end
        rstn = 1'b0;
        drive(1'b1, 4'b0101);
        checks++;
        if (err_cnt !== 8'd0 || locked !== 1'b0 || illegal !== 1'b0 || idx_out !== 3'd0) begin
            failures++;
            $display("FAIL midreset got cnt=%0d lock=%b ill=%b idx=%0d want 0 0 0 0",
                     err_cnt, locked, illegal, idx_out);
        end
        rstn = 1'b1;
        drive(1'b0, 4'b0000);
    endtask

    initial begin
        rstn     = 1'b0;
        code_vld = 1'b0;
        code_in  = '0;
        e_idx = '0; e_ivld = 0; e_ill = 0; e_serr = 0; e_lock = 0; e_cnt = 8'd0;
        m_state = 0; m_run = 0; m_prev = 0;
        #2;
        test_reset();
        test_sequence();
        test_illegal();
        test_seq_err();
        test_gaps();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
